// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with a word-at-a-time line refill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache_direct_mapped #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        flush,
  input  logic [31:0] fetch_addr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                  state;
  logic [31:0]             data_mem [LINES][WORDS];
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [LINES-1:0]        valid_bits;

  logic [OFFSET_BITS-1:0]  req_offset;
  logic [INDEX_BITS-1:0]   req_index;
  logic [TAG_BITS-1:0]     req_tag;
  logic [1:0]              unused_byte_sel;

  logic [TAG_BITS-1:0]     fill_tag;
  logic [INDEX_BITS-1:0]   fill_index;
  logic [OFFSET_BITS-1:0]  fill_cnt;
  logic [OFFSET_BITS-1:0]  next_cnt;

  logic                    hit;
  logic                    start_miss;
  logic                    resp_take;
  logic                    last_word;

  assign {req_tag, req_index, req_offset, unused_byte_sel} = fetch_addr;

  assign hit         = (state == IDLE) && valid_bits[req_index] && (tag_mem[req_index] == req_tag);
  assign instr_valid = hit && rdy && !flush;
  assign instr       = data_mem[req_index][req_offset];

  assign start_miss  = (state == IDLE) && rdy && !flush && !hit;
  // mem_req_valid is always high in FILL, so a response there always matches the current request.
  assign resp_take   = (state == FILL) && rdy && mem_resp_valid;
  assign next_cnt    = fill_cnt + OFFSET_BITS'(1);
  assign last_word   = (fill_cnt == OFFSET_BITS'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid_bits    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      fill_cnt      <= '0;
      fill_tag      <= '0;
      fill_index    <= '0;
    end else if (start_miss) begin
      state         <= FILL;
      fill_tag      <= req_tag;
      fill_index    <= req_index;
      fill_cnt      <= '0;
      mem_req_valid <= 1'b1;
      mem_req_addr  <= {req_tag, req_index, {OFFSET_BITS{1'b0}}, 2'b00};
    end else if (resp_take) begin
      fill_cnt <= next_cnt;
      if (last_word) begin
        valid_bits[fill_index] <= 1'b1;
        mem_req_valid          <= 1'b0;
        state                  <= IDLE;
      end else begin
        mem_req_addr <= {fill_tag, fill_index, next_cnt, 2'b00};
      end
    end
  end

  // NOTE: the tag and data arrays have no reset; valid_bits alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (resp_take) begin
      data_mem[fill_index][fill_cnt] <= mem_resp_data;
      if (last_word) tag_mem[fill_index] <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (instr_valid) hit_count  <= hit_count + 32'd1;
      if (start_miss)  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped: a line-level cache model predicts hit/miss,
// returned words and the memory request sequence; a monitor pops expectations on instr_valid.
`timescale 1ns/1ps
module tb_icache_direct_mapped;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_direct_mapped dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .flush          (flush),
    .fetch_addr     (fetch_addr),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          is_hit;
    int          issue_cyc;
    int          resp_base;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] req_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          resp_count = 0;
  int          last_resp_cyc = 0;
  int          resp_delay = 0;
  int          wait_cnt = 0;
  int          model_misses = 0;
  bit          model_valid [64];
  logic [21:0] model_tag   [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Backing memory: fixed program words at 0x0..0xC, hashed contents elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h00000013;
      32'h4:   mem_word = 32'h00100093;
      32'h8:   mem_word = 32'h00200113;
      32'hC:   mem_word = 32'h00300193;
      default: mem_word = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  // Memory responder: checks each request against the predicted sequence and answers after resp_delay idle cycles.
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (rst_n && mem_req_valid) begin
        if (req_q.size() > 0) check("req_addr", mem_req_addr, req_q[0]);
        else begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got %08h expected no request", mem_req_addr);
        end
        if (wait_cnt < resp_delay) wait_cnt++;
        else begin
          wait_cnt       = 0;
          mem_resp_valid = 1'b1;
          if (rdy) begin
            mem_resp_data = mem_word(mem_req_addr);
            resp_count++;
            last_resp_cyc = cyc;
            if (req_q.size() > 0) void'(req_q.pop_front());
          end else begin
            mem_resp_data = 32'hDEADBEEF;
          end
        end
      end else if (rst_n && ($urandom_range(0, 3) == 0)) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0BAD0;
      end
    end
  end

  // Monitor: the first instr_valid after an issued fetch retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_valid && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("instr", instr, e.data);
        check("resp_per_fetch", 32'(resp_count - e.resp_base), e.is_hit ? 32'd0 : 32'(WORDS));
        if (e.is_hit) check("hit_latency", 32'(cyc - e.issue_cyc), 32'd0);
        else          check("miss_to_valid", 32'(cyc - last_resp_cyc), 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] a);
    exp_t e;
    int   idx;
    int   guard;
    idx      = int'(a[9:4]);
    e.addr   = a;
    e.data   = mem_word({a[31:2], 2'b00});
    e.is_hit = model_valid[idx] && (model_tag[idx] == a[31:10]);
    if (!e.is_hit) begin
      model_misses++;
      for (int w = 0; w < WORDS; w++) req_q.push_back({a[31:4], 4'(w * 4)});
      model_valid[idx] = 1'b1;
      model_tag[idx]   = a[31:10];
    end
    @(posedge clk);
    #1;
    fetch_addr  = a;
    e.issue_cyc = cyc;
    e.resp_base = resp_count;
    sb_q.push_back(e);
    guard = 0;
    while (sb_q.size() > 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: addr %08h got no instr_valid expected one within 500 cycles", a);
      sb_q.delete();
      req_q.delete();
    end
  endtask

  task automatic wait_resp(input int target);
    int g = 0;
    while (resp_count < target && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (resp_count < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_wait: got %0d responses expected %0d", resp_count, target);
    end
  endtask

  task automatic flush_idle_test();
    @(posedge clk);
    #1;
    fetch_addr = 32'h0;
    flush      = 1'b1;
    @(negedge clk);
    check("flush_hides_hit", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    fetch_addr = 32'h800;
    @(posedge clk);
    #1;
    check("flush_blocks_miss", 32'(mem_req_valid), 32'd0);
    fetch_addr = 32'h0;
    flush      = 1'b0;
    @(negedge clk);
    check("hit_after_flush", 32'(instr_valid), 32'd1);
    check("hit_after_flush_data", instr, 32'h00000013);
  endtask

  task automatic flush_fill_test(input logic [31:0] a);
    int base = resp_count;
    fork
      issue(a);
      begin
        wait_resp(base + 1);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_fill_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
    join
    issue(a + 32'h4);
  endtask

  task automatic rdy_low_test(input logic [31:0] a);
    int base = resp_count;
    fork
      issue(a);
      begin
        wait_resp(base + 2);
        #1;
        rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_req_valid", 32'(mem_req_valid), 32'd1);
          check("stall_req_addr", mem_req_addr, {a[31:4], 4'h8});
          check("stall_instr_valid", 32'(instr_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rdy = 1'b1;
      end
    join
  endtask

  task automatic reset_mid_fill_test(input logic [31:0] a);
    int base;
    @(posedge clk);
    #1;
    base       = resp_count;
    fetch_addr = a;
    for (int w = 0; w < WORDS; w++) req_q.push_back({a[31:4], 4'(w * 4)});
    wait_resp(base + 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    req_q.delete();
    wait_cnt     = 0;
    model_misses = 0;
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(a);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = '0;
    end
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset_req_addr", mem_req_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_no_hit", 32'(instr_valid), 32'd0);

    resp_delay = 0;
    issue(32'h0);
    issue(32'hC);
    issue(32'h400);
    issue(32'h0);
    issue(32'h8);

    resp_delay = 3;
    issue(32'h2100);
    issue(32'h2104);
    resp_delay = 0;

    flush_idle_test();
    flush_fill_test(32'h3010);
    rdy_low_test(32'h4020);

    for (int n = 0; n < 150; n++) begin
      resp_delay = $urandom_range(0, 2);
      issue((32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
            32'($urandom_range(0, 15)));
    end
    resp_delay = 0;

    reset_mid_fill_test(32'h5040);
    issue(32'h5048);

`ifdef ICACHE_PERF_EN
    check("miss_count", miss_count, 32'(model_misses));
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
Direct-mapped, read-only instruction cache. It is the responder for the instruction fetcher's address/valid/instruction interface. A hit answers in the same cycle, combinationally from registered arrays. A miss triggers a line-refill FSM that fetches words one at a time from the memory controller's word-read port.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines).
OFFSET_BITS, 2, log2 of words per line (4 words = 16 B).
TAG_BITS, 32-INDEX_BITS-OFFSET_BITS-2, tag width (derived, localparam).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
rdy  input  1  global run enable; low freezes all state.
flush  input  1  pipeline flush from CDB; cache contents unaffected.
fetch_addr  input  32  fetcher PC request; bits [1:0] ignored.
instr_valid  output  1  fetch_addr hit; instr holds its word.
instr  output  32  instruction at fetch_addr.
mem_req_valid  output  1  word read request to memory controller.
mem_req_addr  output  32  word-aligned request address.
mem_resp_valid  input  1  one-cycle pulse: mem_resp_data valid for current request.
mem_resp_data  input  32  returned word.

Behaviour:
- Address split: offset = fetch_addr[OFFSET_BITS+1:2]; index = next INDEX_BITS bits; tag = upper TAG_BITS.
- Storage: data[2^INDEX_BITS][2^OFFSET_BITS] x32, tag[2^INDEX_BITS], valid[2^INDEX_BITS]; all writes on clk posedge.
- hit = valid[index] && tag[index]==tag, evaluated in state IDLE only.
- instr_valid = hit && state==IDLE && rdy && !flush; combinational, 0-cycle latency.
- instr = data[index][offset] whenever hit; otherwise value is don't-care.
- Reset (rst_n low, async): all valid bits 0; state IDLE; mem_req_valid 0; mem_req_addr 0; fill counter 0. Tag and data arrays are not reset.
- FSM states IDLE, FILL.
  - IDLE -> FILL when rdy && !flush && !hit. On this edge:
    - latch line base {tag,index,OFFSET_BITS'b0,2'b0};
    - counter <= 0;
    - mem_req_valid <= 1; mem_req_addr <= line base.
  - FILL, on a cycle with rdy && mem_resp_valid:
    - data[index][counter] <= mem_resp_data; counter increments.
    - If counter was not the last word: mem_req_addr <= base + 4*(counter+1) on the same edge; mem_req_valid stays 1.
    - If counter == 2^OFFSET_BITS-1: tag[index] <= latched tag; valid[index] <= 1; mem_req_valid <= 0; -> IDLE.
  - FILL without mem_resp_valid: hold mem_req_valid and mem_req_addr stable.
- Memory protocol:
  - One outstanding request.
  - Each response consumes the current request.
  - The next address is visible from the cycle after a response.
  - Responses while mem_req_valid==0 or rdy==0 are ignored.
- Refill always starts at word 0 (no critical-word-first). The first hit after refill comes in the first IDLE cycle with an unchanged fetch_addr, i.e. miss-to-valid = 2^OFFSET_BITS responses + 1 cycle.
- flush:
  - An in-flight FILL completes normally; the line is still installed.
  - In IDLE, flush suppresses instr_valid and blocks miss start for that cycle.
- rdy low: no state, array or counter change; outputs hold; instr_valid forced 0.
- fetch_addr changes during FILL do not affect the refill (uses latched base).
- Replacement: new line overwrites index unconditionally. No write path, no coherence with data stores (no self-modifying code).
- Async reset mid-FILL abandons the refill; that line stays invalid.

Optional Feature:
ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count increments on each cycle instr_valid==1.
  - miss_count increments on each IDLE->FILL transition.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

Test Plan:
- Reset, fetch_addr=0x0, memory returns 0x00000013,0x00100093,0x00200113,0x00300193 -> requests 0x0,0x4,0x8,0xC in order; instr_valid=1 with instr=0x00000013 one cycle after 4th response; then addr 0xC hits immediately with 0x00300193.
- Fill line 0x0, then fetch 0x400 (same index, INDEX_BITS=6) -> miss, refill from 0x400; afterwards 0x0 misses again (eviction).
- Memory inserts 3 idle cycles before each response -> mem_req_addr/mem_req_valid stable during waits; 4 words written in order.
- Assert flush on 2nd response cycle of refill -> fill completes, valid set; instr_valid 0 during flush cycle.
- rdy low for 5 cycles mid-FILL with mem_resp_valid pulsed inside window -> pulse ignored, counter unchanged, refill resumes when rdy=1.
- rst_n asserted after 2 responses -> mem_req_valid=0 immediately; re-fetch of same addr misses and refills from word 0.
